rv_mem: RTL and testbench
=========================

// Module: rv_mem
// PURPOSE
//  Memory stage (Q103H) of the 5-stage RV32I pipe; consumes the EXE outputs registered into Q103H.
//  Issues load/store to data memory over a req/gnt/rvalid handshake, aligns store data, and extracts and extends load data.
//  Selects the writeback value (ALU/MEM/PC+4), registers it into Q104H, and stalls the pipe while an access is in flight.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles in REQ+RESP before abort; 0 disables the timeout
// PORTS
//  clk                 in  1   clock, rising edge
//  rst                 in  1   asynchronous, active-low reset
//  valid_Q103H         in  1   instruction valid in Q103H
//  mem_rd_en_Q103H     in  1   load
//  mem_wr_en_Q103H     in  1   store (rd_en and wr_en never both 1)
//  funct3_Q103H        in  3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  sel_wb_Q103H        in  2   0 ALU, 1 MEM, 2 PC+4, 3 -> 0
//  alu_out_Q103H       in  32  effective address / ALU result
//  dmem_wr_data_Q103H  in  32  store data (rs2, already forwarded)
//  pc_plus4_Q103H      in  32  link value
//  dmem_req            out 1   request valid
//  dmem_we             out 1   1 store, 0 load
//  dmem_addr           out 32  {alu_out[31:2],2'b00}
//  dmem_be             out 4   byte enables
//  dmem_wdata          out 32  lane-aligned store data
//  dmem_gnt            in  1   request accepted this cycle
//  dmem_rvalid         in  1   load data valid
//  dmem_rdata          in  32  load word
//  stall_Q103H         out 1   hold Q100H..Q103H this cycle
//  wb_data_Q103H       out 32  combinational wb value (forwarding)
//  wb_data_Q104H       out 32  registered wb value
//  valid_Q104H         out 1   registered valid
//  dmem_err_Q103H      out 1   one-cycle pulse on timeout abort
//  misalign_Q103H      out 1   misaligned access (macro-gated)
// BEHAVIOUR
//  - FSM IDLE/REQ/RESP. IDLE: mem op = valid & (rd|wr) -> dmem_req=1 combinationally.
//    gnt & store -> IDLE (no stall); gnt & load -> RESP; !gnt -> REQ.
//    REQ: hold req/we/addr/be/wdata stable until gnt; transitions as in IDLE.
//    RESP: req=0; rvalid -> IDLE. rvalid is honoured only in RESP; ignored otherwise.
//  - stall_Q103H = mem op & !(store & gnt) & !(state==RESP & rvalid) & !timeout.
//    Minimum load cost: 1 stall cycle (gnt at cycle 0, rvalid at cycle 1).
//  - Store: SB be=4'b0001<<a[1:0], wdata={4{d[7:0]}}; SH be=a[1] ? 1100 : 0011, wdata={2{d[15:0]}}; SW be=1111.
//  - Load: byte/half selected by a[1:0]/a[1] from rdata; B/H sign-extend, BU/HU zero-extend, W pass-through.
//  - wb_data_Q103H = mux(sel_wb); MEM selects extracted rdata (valid only in the rvalid cycle).
//  - Q104H regs load {wb_data_Q103H, valid_Q103H} when !stall_Q103H. While stalled: valid_Q104H=0, data held.
//  - Timeout: counter counts in REQ/RESP and clears in IDLE. At TIMEOUT_CYC: pulse dmem_err_Q103H, go to IDLE, drop stall;
//    Q104H takes wb=0 with valid=1.
//  - Reset (any state, mid-access included): state=IDLE, counter=0, wb_data_Q104H=0, valid_Q104H=0.
//    Outputs reset to dmem_req=0, stall=0, dmem_err=0, misalign=0. A late rvalid after reset is ignored.
//  - A new access is accepted only in IDLE; back-to-back ops each get a full handshake.
// CONFIGURATION
//  RV_MEM_MISALIGN_CHK_EN defined: H with a[0]=1 or W with a[1:0]!=0 -> no dmem_req, misalign_Q103H=1 for that cycle,
//    no stall, wb=0, and Q104H advances.
//  Undefined: misalign_Q103H tied 0; H uses a[1] only and W ignores a[1:0] (address truncated).
// TESTING
//  - SW a=0x100 d=0xDEADBEEF, gnt same cycle -> addr=0x100, be=1111, wdata=0xDEADBEEF, stall=0.
//  - SB a=0x103 d=0x5A, gnt after 3 cycles -> be=1000, wdata=0x5A5A5A5A held stable; stall=1 for 3 cycles.
//  - LB a=0x102 rdata=0x0080FF00, rvalid 1 cycle after gnt -> wb=0xFFFFFF80 next to Q104H; LBU -> 0x00000080.
//  - LH a=0x102 rdata=0x8001xxxx -> 0xFFFF8001; with macro, LW a=0x101 -> misalign=1, dmem_req=0.
//  - TIMEOUT_CYC=4, load granted but no rvalid -> dmem_err pulse at cycle 4, IDLE, wb_data_Q104H=0.
//  - rst low during RESP, then rvalid after release -> state stays IDLE, valid_Q104H=0, no spurious writeback.

Source files
------------

// File: rtl/rv_mem.sv
// rv_mem: memory stage (Q103H) of the 5-stage RV32I pipe.
// Issues loads/stores over a req/gnt/rvalid handshake, lane-aligns store
// data, extracts and extends load data, selects the writeback value and
// registers it into Q104H. Holds the pipe while an access is outstanding.
// Optional feature macro: RV_MEM_MISALIGN_CHK_EN (misaligned H/W accesses are
// flagged and suppressed instead of silently truncated).
module rv_mem #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_Q103H,
  input  logic        mem_rd_en_Q103H,
  input  logic        mem_wr_en_Q103H,
  input  logic [2:0]  funct3_Q103H,
  input  logic [1:0]  sel_wb_Q103H,
  input  logic [31:0] alu_out_Q103H,
  input  logic [31:0] dmem_wr_data_Q103H,
  input  logic [31:0] pc_plus4_Q103H,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_Q103H,
  output logic [31:0] wb_data_Q103H,
  output logic [31:0] wb_data_Q104H,
  output logic        valid_Q104H,
  output logic        dmem_err_Q103H,
  output logic        misalign_Q103H
);

  localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic        mem_op;
  logic        misalign_raw;
  logic        timeout_hit;
  logic        issue;
  logic        resp_done;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Reset forces every combinational handshake output low, even with an op presented.
  assign mem_op = rst & valid_Q103H & (mem_rd_en_Q103H | mem_wr_en_Q103H);

`ifdef RV_MEM_MISALIGN_CHK_EN
  // Halfword on an odd byte or word off a word boundary is flagged as misaligned.
  always_comb begin
    misalign_raw = 1'b0;
    case (funct3_Q103H[1:0])
      2'b01:   misalign_raw = alu_out_Q103H[0];
      2'b10:   misalign_raw = (alu_out_Q103H[1:0] != 2'b00);
      default: misalign_raw = 1'b0;
    endcase
  end
`else
  assign misalign_raw = 1'b0;
`endif

  assign misalign_Q103H = mem_op & misalign_raw;

  // A completing response in the same cycle wins over the timeout abort.
  assign resp_done   = (state == RESP) & dmem_rvalid;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (state != IDLE) &&
                       (cnt == CW'(TIMEOUT_CYC)) && !resp_done;

  assign issue    = mem_op & ~misalign_Q103H & ((state == IDLE) | (state == REQ)) & ~timeout_hit;
  assign dmem_req = issue;
  assign dmem_we  = mem_op & mem_wr_en_Q103H;
  assign dmem_addr = {alu_out_Q103H[31:2], 2'b00};

  assign stall_Q103H = mem_op & ~misalign_Q103H & ~(mem_wr_en_Q103H & issue & dmem_gnt) &
                       ~resp_done & ~timeout_hit;

  assign dmem_err_Q103H = timeout_hit;

  // Byte enables and replicated store data by access size.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = dmem_wr_data_Q103H;
    case (funct3_Q103H[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << alu_out_Q103H[1:0];
        dmem_wdata = {4{dmem_wr_data_Q103H[7:0]}};
      end
      2'b01: begin
        dmem_be    = alu_out_Q103H[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{dmem_wr_data_Q103H[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = dmem_wr_data_Q103H;
      end
    endcase
  end

  // Pick the addressed byte/half from the load word and extend it.
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (alu_out_Q103H[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = alu_out_Q103H[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_Q103H)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  // Writeback select; aborted and misaligned accesses write back zero.
  always_comb begin
    case (sel_wb_Q103H)
      2'd1:    wb_data_Q103H = ld_data;
      2'd2:    wb_data_Q103H = pc_plus4_Q103H;
      default: wb_data_Q103H = alu_out_Q103H;
    endcase
    if (timeout_hit | misalign_Q103H) wb_data_Q103H = 32'h0;
  end

  // Q104H pipeline register: advances when not stalled, bubbles while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data_Q104H <= 32'h0;
      valid_Q104H   <= 1'b0;
    end else if (!stall_Q103H) begin
      wb_data_Q104H <= wb_data_Q103H;
      valid_Q104H   <= valid_Q103H;
    end else begin
      valid_Q104H   <= 1'b0;
    end
  end

  // Handshake FSM with the in-flight cycle counter used for the timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            if (dmem_gnt) begin
              state <= mem_wr_en_Q103H ? IDLE : RESP;
              cnt   <= mem_wr_en_Q103H ? '0 : CW'(1);
            end else begin
              state <= REQ;
              cnt   <= CW'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        REQ: begin
          if (timeout_hit || !issue) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (dmem_gnt) begin
            state <= mem_wr_en_Q103H ? IDLE : RESP;
            cnt   <= mem_wr_en_Q103H ? '0 : cnt + CW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (resp_done || timeout_hit) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem.sv
// tb_rv_mem: self-checking bench for rv_mem (TIMEOUT_CYC = 4).
// Retiring instructions push their expected Q104H value into a queue when
// driven; the value is popped and compared when the stage retires it.
module tb_rv_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_Q103H, mem_rd_en_Q103H, mem_wr_en_Q103H;
  logic [2:0]  funct3_Q103H;
  logic [1:0]  sel_wb_Q103H;
  logic [31:0] alu_out_Q103H, dmem_wr_data_Q103H, pc_plus4_Q103H;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall_Q103H;
  logic [31:0] wb_data_Q103H, wb_data_Q104H;
  logic        valid_Q104H, dmem_err_Q103H, misalign_Q103H;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp;

  rv_mem #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .valid_Q103H(valid_Q103H), .mem_rd_en_Q103H(mem_rd_en_Q103H),
    .mem_wr_en_Q103H(mem_wr_en_Q103H), .funct3_Q103H(funct3_Q103H),
    .sel_wb_Q103H(sel_wb_Q103H), .alu_out_Q103H(alu_out_Q103H),
    .dmem_wr_data_Q103H(dmem_wr_data_Q103H), .pc_plus4_Q103H(pc_plus4_Q103H),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_Q103H(stall_Q103H), .wb_data_Q103H(wb_data_Q103H),
    .wb_data_Q104H(wb_data_Q104H), .valid_Q104H(valid_Q104H),
    .dmem_err_Q103H(dmem_err_Q103H), .misalign_Q103H(misalign_Q103H)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] pc4);
    valid_Q103H = v; mem_rd_en_Q103H = rd; mem_wr_en_Q103H = wr;
    funct3_Q103H = f3; sel_wb_Q103H = sel; alu_out_Q103H = a;
    dmem_wr_data_Q103H = d; pc_plus4_Q103H = pc4;
  endtask

  task automatic mem_if(input logic g, input logic rv, input logic [31:0] rd);
    dmem_gnt = g; dmem_rvalid = rv; dmem_rdata = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'b010, 2'd0, 32'h0, 32'h0, 32'h0);
    mem_if(1'b0, 1'b0, 32'h0);
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h40, 32'h0, 32'h0);
    mem_if(1'b1, 1'b1, 32'h1234);
    @(negedge clk);
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b want 0", dmem_req); end
    n_checks++; if (stall_Q103H !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", stall_Q103H); end
    n_checks++; if (dmem_err_Q103H !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", dmem_err_Q103H); end
    n_checks++; if (misalign_Q103H !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %0b want 0", misalign_Q103H); end
    n_checks++; if (valid_Q104H !== 1'b0) begin n_fail++; $display("FAIL rst_valid104: got %0b want 0", valid_Q104H); end
    n_checks++; if (wb_data_Q104H !== 32'h0) begin n_fail++; $display("FAIL rst_wb104: got %h want 0", wb_data_Q104H); end
    idle();
    @(negedge clk);
    rst = 1'b1;
    cyc_end();
  endtask

  task automatic test_store_word();
    drive(1'b1, 1'b0, 1'b1, 3'b010, 2'd0, 32'h100, 32'hDEADBEEF, 32'h8);
    mem_if(1'b1, 1'b0, 32'h0);
    exp_q.push_back({1'b1, 32'h100});
    @(negedge clk);
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL sw_req: got %0b want 1", dmem_req); end
    n_checks++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL sw_we: got %0b want 1", dmem_we); end
    n_checks++; if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr: got %h want 00000100", dmem_addr); end
    n_checks++; if (dmem_be !== 4'b1111) begin n_fail++; $display("FAIL sw_be: got %b want 1111", dmem_be); end
    n_checks++; if (dmem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", dmem_wdata); end
    n_checks++; if (stall_Q103H !== 1'b0) begin n_fail++; $display("FAIL sw_stall: got %0b want 0", stall_Q103H); end
    cyc_end();
    idle();
    exp = exp_q.pop_front();
    n_checks++; if ({valid_Q104H, wb_data_Q104H} !== exp) begin n_fail++; $display("FAIL sw_q104: got %h want %h", {valid_Q104H, wb_data_Q104H}, exp); end
  endtask

  task automatic test_store_byte_wait();
    drive(1'b1, 1'b0, 1'b1, 3'b000, 2'd0, 32'h103, 32'h0000005A, 32'h8);
    exp_q.push_back({1'b1, 32'h103});
    for (int i = 0; i < 4; i++) begin
      mem_if(i == 3, 1'b0, 32'h0);
      @(negedge clk);
      n_checks++; if (dmem_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be[%0d]: got %b want 1000", i, dmem_be); end
      n_checks++; if (dmem_wdata !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL sb_wdata[%0d]: got %h want 5a5a5a5a", i, dmem_wdata); end
      n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL sb_req[%0d]: got %0b want 1", i, dmem_req); end
      n_checks++; if (stall_Q103H !== (i != 3)) begin n_fail++; $display("FAIL sb_stall[%0d]: got %0b want %0b", i, stall_Q103H, i != 3); end
      cyc_end();
      if (i < 3) begin
        n_checks++; if (valid_Q104H !== 1'b0) begin n_fail++; $display("FAIL sb_bubble[%0d]: got %0b want 0", i, valid_Q104H); end
      end
    end
    idle();
    exp = exp_q.pop_front();
    n_checks++; if ({valid_Q104H, wb_data_Q104H} !== exp) begin n_fail++; $display("FAIL sb_q104: got %h want %h", {valid_Q104H, wb_data_Q104H}, exp); end
  endtask

  task automatic test_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                           input logic [31:0] want);
    drive(1'b1, 1'b1, 1'b0, f3, 2'd1, a, 32'h0, 32'h8);
    mem_if(1'b1, 1'b1, 32'hFFFFFFFF);
    exp_q.push_back({1'b1, want});
    @(negedge clk);
    n_checks++; if ({dmem_req, dmem_we, stall_Q103H} !== 3'b101) begin n_fail++; $display("FAIL ld%0d_issue req/we/stall: got %b want 101", f3, {dmem_req, dmem_we, stall_Q103H}); end
    n_checks++; if (dmem_addr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL ld%0d_addr: got %h want %h", f3, dmem_addr, {a[31:2], 2'b00}); end
    cyc_end();
    n_checks++; if (valid_Q104H !== 1'b0) begin n_fail++; $display("FAIL ld%0d_bubble: got %0b want 0", f3, valid_Q104H); end
    mem_if(1'b0, 1'b1, rd);
    @(negedge clk);
    n_checks++; if ({dmem_req, stall_Q103H} !== 2'b00) begin n_fail++; $display("FAIL ld%0d_resp req/stall: got %b want 00", f3, {dmem_req, stall_Q103H}); end
    n_checks++; if (wb_data_Q103H !== want) begin n_fail++; $display("FAIL ld%0d_wb103: got %h want %h", f3, wb_data_Q103H, want); end
    cyc_end();
    idle();
    exp = exp_q.pop_front();
    n_checks++; if ({valid_Q104H, wb_data_Q104H} !== exp) begin n_fail++; $display("FAIL ld%0d_q104: got %h want %h", f3, {valid_Q104H, wb_data_Q104H}, exp); end
  endtask

  task automatic test_load_late_gnt();
    drive(1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h204, 32'h0, 32'h8);
    exp_q.push_back({1'b1, 32'hCAFEF00D});
    mem_if(1'b0, 1'b1, 32'h11111111);
    @(negedge clk);
    n_checks++; if ({dmem_req, stall_Q103H} !== 2'b11) begin n_fail++; $display("FAIL late_c0 req/stall: got %b want 11", {dmem_req, stall_Q103H}); end
    cyc_end();
    mem_if(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    n_checks++; if ({dmem_req, stall_Q103H} !== 2'b11) begin n_fail++; $display("FAIL late_c1 req/stall: got %b want 11", {dmem_req, stall_Q103H}); end
    cyc_end();
    mem_if(1'b0, 1'b1, 32'hCAFEF00D);
    @(negedge clk);
    n_checks++; if ({dmem_req, stall_Q103H} !== 2'b00) begin n_fail++; $display("FAIL late_c2 req/stall: got %b want 00", {dmem_req, stall_Q103H}); end
    cyc_end();
    idle();
    exp = exp_q.pop_front();
    n_checks++; if ({valid_Q104H, wb_data_Q104H} !== exp) begin n_fail++; $display("FAIL late_q104: got %h want %h", {valid_Q104H, wb_data_Q104H}, exp); end
  endtask

  task automatic test_timeout();
    drive(1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h300, 32'h0, 32'h8);
    mem_if(1'b1, 1'b0, 32'h0);
    exp_q.push_back({1'b1, 32'h0});
    cyc_end();
    mem_if(1'b0, 1'b0, 32'hABCDABCD);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if ({dmem_err_Q103H, stall_Q103H, dmem_req} !== 3'b010) begin n_fail++; $display("FAIL to_wait[%0d] err/stall/req: got %b want 010", i, {dmem_err_Q103H, stall_Q103H, dmem_req}); end
      cyc_end();
    end
    @(negedge clk);
    n_checks++; if ({dmem_err_Q103H, stall_Q103H} !== 2'b10) begin n_fail++; $display("FAIL to_abort err/stall: got %b want 10", {dmem_err_Q103H, stall_Q103H}); end
    cyc_end();
    idle();
    exp = exp_q.pop_front();
    n_checks++; if ({valid_Q104H, wb_data_Q104H} !== exp) begin n_fail++; $display("FAIL to_q104: got %h want %h", {valid_Q104H, wb_data_Q104H}, exp); end
    @(negedge clk);
    n_checks++; if (dmem_err_Q103H !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got %0b want 0", dmem_err_Q103H); end
    cyc_end();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b1, 3'b010, 2'd0, 32'h10, 32'h11223344, 32'h8);
    mem_if(1'b1, 1'b0, 32'h0);
    exp_q.push_back({1'b1, 32'h10});
    cyc_end();
    exp = exp_q.pop_front();
    n_checks++; if ({valid_Q104H, wb_data_Q104H} !== exp) begin n_fail++; $display("FAIL b2b_sw: got %h want %h", {valid_Q104H, wb_data_Q104H}, exp); end
    drive(1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h20, 32'h0, 32'h8);
    exp_q.push_back({1'b1, 32'h55667788});
    @(negedge clk);
    n_checks++; if ({dmem_req, dmem_we, stall_Q103H} !== 3'b101) begin n_fail++; $display("FAIL b2b_lw_issue: got %b want 101", {dmem_req, dmem_we, stall_Q103H}); end
    cyc_end();
    mem_if(1'b0, 1'b1, 32'h55667788);
    cyc_end();
    exp = exp_q.pop_front();
    n_checks++; if ({valid_Q104H, wb_data_Q104H} !== exp) begin n_fail++; $display("FAIL b2b_lw: got %h want %h", {valid_Q104H, wb_data_Q104H}, exp); end
    drive(1'b1, 1'b0, 1'b0, 3'b000, 2'd2, 32'h77, 32'h0, 32'h1234);
    mem_if(1'b0, 1'b0, 32'h0);
    exp_q.push_back({1'b1, 32'h1234});
    cyc_end();
    exp = exp_q.pop_front();
    n_checks++; if ({valid_Q104H, wb_data_Q104H} !== exp) begin n_fail++; $display("FAIL b2b_pc4: got %h want %h", {valid_Q104H, wb_data_Q104H}, exp); end
    drive(1'b1, 1'b0, 1'b0, 3'b000, 2'd3, 32'h99, 32'h0, 32'h1234);
    exp_q.push_back({1'b1, 32'h99});
    cyc_end();
    exp = exp_q.pop_front();
    n_checks++; if ({valid_Q104H, wb_data_Q104H} !== exp) begin n_fail++; $display("FAIL b2b_sel3: got %h want %h", {valid_Q104H, wb_data_Q104H}, exp); end
    idle();
    cyc_end();
    n_checks++; if (valid_Q104H !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble: got %0b want 0", valid_Q104H); end
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h101, 32'h0, 32'h8);
`ifdef RV_MEM_MISALIGN_CHK_EN
    mem_if(1'b0, 1'b0, 32'h0);
    exp_q.push_back({1'b1, 32'h0});
    @(negedge clk);
    n_checks++; if ({misalign_Q103H, dmem_req, stall_Q103H} !== 3'b100) begin n_fail++; $display("FAIL mis_flag mis/req/stall: got %b want 100", {misalign_Q103H, dmem_req, stall_Q103H}); end
    cyc_end();
`else
    mem_if(1'b1, 1'b0, 32'h0);
    exp_q.push_back({1'b1, 32'hA5A5A5A5});
    @(negedge clk);
    n_checks++; if ({misalign_Q103H, dmem_req} !== 2'b01) begin n_fail++; $display("FAIL mis_off mis/req: got %b want 01", {misalign_Q103H, dmem_req}); end
    n_checks++; if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL mis_trunc_addr: got %h want 00000100", dmem_addr); end
    cyc_end();
    mem_if(1'b0, 1'b1, 32'hA5A5A5A5);
    cyc_end();
`endif
    idle();
    exp = exp_q.pop_front();
    n_checks++; if ({valid_Q104H, wb_data_Q104H} !== exp) begin n_fail++; $display("FAIL mis_q104: got %h want %h", {valid_Q104H, wb_data_Q104H}, exp); end
  endtask

  task automatic test_reset_mid_access();
    drive(1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h400, 32'h0, 32'h8);
    mem_if(1'b1, 1'b0, 32'h0);
    cyc_end();
    idle();
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({valid_Q104H, wb_data_Q104H} !== 33'h0) begin n_fail++; $display("FAIL rmid_q104: got %h want 0", {valid_Q104H, wb_data_Q104H}); end
    @(negedge clk);
    rst = 1'b1;
    cyc_end();
    mem_if(1'b0, 1'b1, 32'hFFFFFFFF);
    @(negedge clk);
    n_checks++; if ({dmem_req, stall_Q103H, dmem_err_Q103H} !== 3'b000) begin n_fail++; $display("FAIL rmid_late_rvalid req/stall/err: got %b want 000", {dmem_req, stall_Q103H, dmem_err_Q103H}); end
    cyc_end();
    n_checks++; if (valid_Q104H !== 1'b0) begin n_fail++; $display("FAIL rmid_spurious_wb: got %0b want 0", valid_Q104H); end
    drive(1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'h500, 32'h0, 32'h8);
    mem_if(1'b0, 1'b0, 32'h0);
    exp_q.push_back({1'b1, 32'h0BADF00D});
    @(negedge clk);
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_idle_req: got %0b want 1", dmem_req); end
    cyc_end();
    mem_if(1'b1, 1'b0, 32'h0);
    cyc_end();
    mem_if(1'b0, 1'b1, 32'h0BADF00D);
    cyc_end();
    idle();
    exp = exp_q.pop_front();
    n_checks++; if ({valid_Q104H, wb_data_Q104H} !== exp) begin n_fail++; $display("FAIL rmid_next_q104: got %h want %h", {valid_Q104H, wb_data_Q104H}, exp); end
  endtask

  initial begin
    $display("[TB] rv_mem bench start");
    test_reset();
    test_store_word();
    test_store_byte_wait();
    test_load(3'b000, 32'h102, 32'h0080FF00, 32'hFFFFFF80);
    test_load(3'b100, 32'h102, 32'h0080FF00, 32'h00000080);
    test_load(3'b001, 32'h102, 32'h80011234, 32'hFFFF8001);
    test_load(3'b101, 32'h100, 32'h12348765, 32'h00008765);
    test_load(3'b010, 32'h108, 32'h89ABCDEF, 32'h89ABCDEF);
    test_load_late_gnt();
    test_timeout();
    test_back_to_back();
    test_misalign();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
